keypad_input_conditioner: RTL and testbench
===========================================

Name: keypad_input_conditioner

Overview:
- Front-end stage directly upstream of the keypad FSM; its outputs drive that FSM's ZBUT, OBUT and SECI inputs.
- Synchronises and debounces the two raw push-buttons (digit 0, digit 1).
- Converts each accepted press into a single-cycle pulse.
- Raises a single-cycle security pulse when both buttons are held together, and suppresses digit pulses while that condition exists.

Parameters:
- DB_CYCLES, 4, consecutive synchronised samples at a new level required to accept a level change (legal range 2..15).
- CNT_W, 4, debounce counter width; must hold DB_CYCLES.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RSTN  input  1  synchronous active-low reset.
- ENBL  input  1  system enable, same signal that feeds the keypad FSM.
- ZRAW  input  1  raw asynchronous digit-0 button, active-high.
- ORAW  input  1  raw asynchronous digit-1 button, active-high.
- ZBUT  output  1  one-cycle pulse per accepted digit-0 press.
- OBUT  output  1  one-cycle pulse per accepted digit-1 press.
- SECI  output  1  one-cycle pulse on dual-press violation.
- BUSY  output  1  high while either debounced button level is pressed.

Behaviour:
- Reset, when RSTN=0 at a posedge:
  - Synchroniser flops, counters and debounced levels go to 0 (released).
  - Each per-button FSM returns to REL.
  - ZBUT, OBUT, SECI and BUSY are 0 from the following cycle.
  - Reset mid-count discards the partial count; no pulse is emitted for that press.
- Synchroniser: two flops per raw input. Only the second-stage output (zs, os) is used downstream.
- Per-button FSM (identical instances for Z and O), states REL, PCHK, HELD, RCHK:
  - REL: sync=1 -> PCHK with cnt=1; else stay.
  - PCHK: sync=1 -> cnt+1. When cnt reaches DB_CYCLES -> HELD, and a one-cycle "accept" strobe is raised. sync=0 -> REL, cnt=0 (glitch rejected).
  - HELD: sync=0 -> RCHK with cnt=1; else stay.
  - RCHK: sync=0 -> cnt+1. When cnt reaches DB_CYCLES -> REL. sync=1 -> HELD, cnt=0.
  - Debounced level = 1 in HELD and RCHK.
- Latency:
  - Raw goes high before edge 1 and stays high: ZBUT/OBUT are high in the cycle after edge 3+DB_CYCLES and low after the next edge. With default DB_CYCLES=4, the pulse is high between edges 7 and 8.
  - All outputs are registered.
- One pulse per press: no further pulse until the FSM has passed back through REL. Holding a button indefinitely gives exactly one pulse.
- Dual press (violation):
  - Triggers when an accept strobe fires while the other button's debounced level is 1, or both strobes fire in the same cycle.
  - Result: SECI pulses for one cycle; ZBUT and OBUT stay 0 for that cycle.
  - An "armed" flag is set on SECI and cleared only when both FSMs are in REL. While armed, all further accept strobes are swallowed, with no ZBUT, OBUT or SECI.
- ENBL=0:
  - Outputs ZBUT, OBUT and SECI are forced 0 and both FSMs are held in REL.
  - The armed flag is cleared and the synchronisers keep running.
  - A button already held when ENBL rises must be released and re-pressed before it produces a pulse; it produces no pulse on ENBL rise.
- ZBUT, OBUT and SECI are mutually exclusive in every cycle.
- BUSY = OR of the debounced levels, registered, and 0 while ENBL=0.

Test Plan:
- Reset/idle: hold RSTN=0 for 3 cycles, then release with ZRAW=ORAW=0 for 20 cycles -> all outputs 0 throughout.
- Clean press: ENBL=1, DB_CYCLES=4, ZRAW high before edge 1 for 12 cycles -> ZBUT=1 only between edges 7 and 8; BUSY=1 from edge 7; OBUT=SECI=0.
- Glitch reject: ORAW high for 3 sampled cycles, then low -> no OBUT; FSM returns to REL. Release bounce (ORAW 1-0-1 within a held press) -> still only one OBUT pulse.
- Dual press: ZRAW held and ZBUT already pulsed, then ORAW rises -> after 3+DB_CYCLES edges SECI=1 for one cycle, OBUT=0. Toggling ORAW again while ZRAW is held -> no further outputs until both buttons are released.
- Simultaneous: ZRAW and ORAW rise together -> one SECI pulse, no ZBUT/OBUT.
- Enable/reset mid-operation:
  - ENBL drops during PCHK -> no pulse.
  - ENBL rises with ZRAW already held -> no pulse until release and re-press.
  - RSTN=0 asserted with cnt=3 -> no pulse after reset is released.

Source files
------------

// File: rtl/keypad_input_conditioner_if.sv
// Keypad conditioner signal bundle: enable and raw buttons in, conditioned strobes out.
interface keypad_input_conditioner_if;
   logic ENBL;
   logic ZRAW;
   logic ORAW;
   logic ZBUT;
   logic OBUT;
   logic SECI;
   logic BUSY;

   modport slave  (input ENBL, ZRAW, ORAW, output ZBUT, OBUT, SECI, BUSY);
   modport master (output ENBL, ZRAW, ORAW, input ZBUT, OBUT, SECI, BUSY);
endinterface

// File: rtl/keypad_input_conditioner.sv
// Synchronises and debounces the two keypad buttons, emits one pulse per press
// and a security pulse when both buttons are held together.
module keypad_input_conditioner #(
   parameter int unsigned DB_CYCLES = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   keypad_input_conditioner_if.slave    kp
);

   localparam int unsigned NB = 2;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      REL  = 2'd0,
      PCHK = 2'd1,
      HELD = 2'd2,
      RCHK = 2'd3
   } btn_state_e;

   // Index 0 is the digit-0 button, index 1 the digit-1 button.
   logic [NB-1:0]    sync1_q, sync2_q;
   btn_state_e       state_q [NB];
   btn_state_e       state_d [NB];
   logic [CNT_W-1:0] cnt_q [NB];
   logic [CNT_W-1:0] cnt_d [NB];
   logic [NB-1:0]    blk_q, blk_d;
   logic [NB-1:0]    acc_q, acc_d;
   logic [NB-1:0]    lvl;
   logic             armed_q, armed_d;
   logic             viol;
   logic             zbut_q, zbut_d;
   logic             obut_q, obut_d;
   logic             seci_q, seci_d;
   logic             busy_q, busy_d;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         sync1_q <= '0;
         sync2_q <= '0;
         for (int unsigned i = 0; i < NB; i++) begin
            state_q[i] <= REL;
            cnt_q[i]   <= '0;
         end
         blk_q   <= '0;
         acc_q   <= '0;
         armed_q <= 1'b0;
         zbut_q  <= 1'b0;
         obut_q  <= 1'b0;
         seci_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= {kp.ORAW, kp.ZRAW};
         sync2_q <= sync1_q;
         for (int unsigned i = 0; i < NB; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         blk_q   <= blk_d;
         acc_q   <= acc_d;
         armed_q <= armed_d;
         zbut_q  <= zbut_d;
         obut_q  <= obut_d;
         seci_q  <= seci_d;
         busy_q  <= busy_d;
      end
   end

   // Per-button debounce FSM; blk keeps a button pressed across enable rise from counting.
   always_comb begin
      for (int unsigned i = 0; i < NB; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         blk_d[i]   = blk_q[i];
         if (!kp.ENBL) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
            blk_d[i]   = sync2_q[i];
         end else begin
            if (!sync2_q[i]) blk_d[i] = 1'b0;
            case (state_q[i])
               REL: begin
                  if (sync2_q[i] && !blk_q[i]) begin
                     state_d[i] = PCHK;
                     cnt_d[i]   = CNT_W'(1);
                  end
               end
               PCHK: begin
                  if (!sync2_q[i]) begin
                     state_d[i] = REL;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] >= DB_LAST) begin
                     state_d[i] = HELD;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
               HELD: begin
                  if (!sync2_q[i]) begin
                     state_d[i] = RCHK;
                     cnt_d[i]   = CNT_W'(1);
                  end
               end
               RCHK: begin
                  if (sync2_q[i]) begin
                     state_d[i] = HELD;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] >= DB_LAST) begin
                     state_d[i] = REL;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
               default: begin
                  state_d[i] = REL;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // Accept strobes, dual-press arbitration and registered output values.
   always_comb begin
      for (int unsigned i = 0; i < NB; i++) begin
         acc_d[i] = kp.ENBL && (state_q[i] == PCHK) && sync2_q[i] && (cnt_q[i] >= DB_LAST);
         lvl[i]   = (state_q[i] == HELD) || (state_q[i] == RCHK);
      end
      viol   = (acc_q[0] && (acc_q[1] || lvl[1])) || (acc_q[1] && lvl[0]);
      zbut_d = kp.ENBL && !armed_q && acc_q[0] && !viol;
      obut_d = kp.ENBL && !armed_q && acc_q[1] && !viol;
      seci_d = kp.ENBL && !armed_q && viol;
      busy_d = kp.ENBL && (|lvl);
      armed_d = armed_q;
      if (!kp.ENBL) begin
         armed_d = 1'b0;
      end else if (seci_d) begin
         armed_d = 1'b1;
      end else if ((state_q[0] == REL) && (state_q[1] == REL)) begin
         armed_d = 1'b0;
      end
   end

   assign kp.ZBUT = zbut_q;
   assign kp.OBUT = obut_q;
   assign kp.SECI = seci_q;
   assign kp.BUSY = busy_q;

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and
// random stimulus against a history-based reference model.
module tb_keypad_input_conditioner;

   localparam int DB = 4;

   logic CLK = 1'b0;
   logic RSTN;
   keypad_input_conditioner_if kp ();

   keypad_input_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .kp   (kp.slave)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int n_z = 0, n_o = 0, n_s = 0, n_b = 0;

   typedef struct {
      logic rn, en, z, o;
      logic ez, eo, es, eb;
   } vec_t;
   vec_t tbl [23];

   // Reference model: debounced level flips once the last DB synchronised
   // samples all disagree with it; a value of 2 marks a disabled cycle.
   logic m_sy1 [2];
   logic m_sy2 [2];
   logic m_lvl [2];
   logic m_acc [2];
   logic m_blk [2];
   logic m_armed, m_zbut, m_obut, m_seci, m_busy;
   int   hist [2][$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int trailing(input int i);
      int n = 0;
      int want = m_lvl[i] ? 0 : 1;
      for (int k = hist[i].size() - 1; k >= 0; k--) begin
         if (hist[i][k] == want) n++;
         else break;
      end
      return n;
   endfunction

   task automatic model_edge();
      logic s [2];
      logic raw [2];
      logic rel [2];
      logic viol;
      raw[0] = kp.ZRAW;
      raw[1] = kp.ORAW;
      if (!RSTN) begin
         for (int i = 0; i < 2; i++) begin
            m_sy1[i] = 1'b0; m_sy2[i] = 1'b0; m_lvl[i] = 1'b0;
            m_acc[i] = 1'b0; m_blk[i] = 1'b0;
            hist[i].delete();
         end
         m_armed = 1'b0; m_zbut = 1'b0; m_obut = 1'b0; m_seci = 1'b0; m_busy = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            s[i]   = m_sy2[i];
            rel[i] = !m_lvl[i] && (trailing(i) == 0);
         end
         viol   = (m_acc[0] && (m_acc[1] || m_lvl[1])) || (m_acc[1] && m_lvl[0]);
         m_zbut = kp.ENBL && !m_armed && m_acc[0] && !viol;
         m_obut = kp.ENBL && !m_armed && m_acc[1] && !viol;
         m_seci = kp.ENBL && !m_armed && viol;
         m_busy = kp.ENBL && (m_lvl[0] || m_lvl[1]);
         if (!kp.ENBL)            m_armed = 1'b0;
         else if (m_seci)         m_armed = 1'b1;
         else if (rel[0] && rel[1]) m_armed = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_acc[i] = 1'b0;
            if (!kp.ENBL) begin
               hist[i].push_back(2);
               m_lvl[i] = 1'b0;
               m_blk[i] = s[i];
            end else begin
               hist[i].push_back(m_blk[i] ? 0 : int'(s[i]));
               m_blk[i] = m_blk[i] && s[i];
               if (trailing(i) >= DB) begin
                  m_lvl[i] = !m_lvl[i];
                  m_acc[i] = m_lvl[i];
               end
            end
            if (hist[i].size() > 32) void'(hist[i].pop_front());
            m_sy2[i] = m_sy1[i];
            m_sy1[i] = raw[i];
         end
      end
   endtask

   // One clock: drive on the falling edge, step model at the rising edge, check 1 ns later.
   task automatic cyc(input logic rn, input logic en, input logic z, input logic o);
      int mx;
      @(negedge CLK);
      RSTN = rn; kp.ENBL = en; kp.ZRAW = z; kp.ORAW = o;
      @(posedge CLK);
      model_edge();
      #1;
      chk("model_zbut", int'(kp.ZBUT), int'(m_zbut));
      chk("model_obut", int'(kp.OBUT), int'(m_obut));
      chk("model_seci", int'(kp.SECI), int'(m_seci));
      chk("model_busy", int'(kp.BUSY), int'(m_busy));
      mx = int'(kp.ZBUT) + int'(kp.OBUT) + int'(kp.SECI);
      chk("mutex", (mx <= 1) ? 1 : 0, 1);
      n_z += int'(kp.ZBUT);
      n_o += int'(kp.OBUT);
      n_s += int'(kp.SECI);
      n_b += int'(kp.BUSY);
   endtask

   task automatic run(input int n, input logic rn, input logic en, input logic z, input logic o);
      for (int k = 0; k < n; k++) cyc(rn, en, z, o);
   endtask

   task automatic clr();
      n_z = 0; n_o = 0; n_s = 0; n_b = 0;
   endtask

   initial begin
      logic rz, ro, ren, rrn;
      RSTN = 1'b0; kp.ENBL = 1'b0; kp.ZRAW = 1'b0; kp.ORAW = 1'b0;

      // Clean digit-0 press: rows 0-2 reset, row 3 is edge 1.
      for (int r = 0; r < 23; r++) begin
         tbl[r] = '{rn: (r >= 3), en: 1'b1, z: (r >= 3 && r <= 14), o: 1'b0,
                    ez: (r == 9), eo: 1'b0, es: 1'b0, eb: (r >= 9 && r <= 20)};
      end
      for (int r = 0; r < 23; r++) begin
         cyc(tbl[r].rn, tbl[r].en, tbl[r].z, tbl[r].o);
         chk($sformatf("tbl_zbut[%0d]", r), int'(kp.ZBUT), int'(tbl[r].ez));
         chk($sformatf("tbl_obut[%0d]", r), int'(kp.OBUT), int'(tbl[r].eo));
         chk($sformatf("tbl_seci[%0d]", r), int'(kp.SECI), int'(tbl[r].es));
         chk($sformatf("tbl_busy[%0d]", r), int'(kp.BUSY), int'(tbl[r].eb));
      end

      // Reset then idle.
      clr();
      run(3, 1'b0, 1'b1, 1'b0, 1'b0);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("idle_pulses", n_z + n_o + n_s, 0);
      chk("idle_busy", n_b, 0);

      // Glitch shorter than the debounce window.
      clr();
      run(3, 1'b1, 1'b1, 1'b0, 1'b1);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("glitch_obut", n_o, 0);
      chk("glitch_busy", n_b, 0);

      // Bounce during a held press still yields one pulse.
      clr();
      run(15, 1'b1, 1'b1, 1'b0, 1'b1);
      run(1, 1'b1, 1'b1, 1'b0, 1'b0);
      run(10, 1'b1, 1'b1, 1'b0, 1'b1);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("bounce_obut", n_o, 1);

      // Dual press: Z held, O joins, O toggles, both released, then Z again.
      clr();
      run(15, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("dual_first_zbut", n_z, 1);
      run(12, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("dual_seci", n_s, 1);
      chk("dual_obut", n_o, 0);
      run(8, 1'b1, 1'b1, 1'b1, 1'b0);
      run(12, 1'b1, 1'b1, 1'b1, 1'b1);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("dual_armed_seci", n_s, 1);
      chk("dual_armed_obut", n_o, 0);
      chk("dual_armed_zbut", n_z, 1);
      run(15, 1'b1, 1'b1, 1'b1, 1'b0);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("dual_rearm_zbut", n_z, 2);

      // Simultaneous press.
      clr();
      run(15, 1'b1, 1'b1, 1'b1, 1'b1);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("simul_seci", n_s, 1);
      chk("simul_digits", n_z + n_o, 0);

      // Enable drops during the press check.
      clr();
      run(4, 1'b1, 1'b1, 1'b1, 1'b0);
      run(5, 1'b1, 1'b0, 1'b1, 1'b0);
      run(3, 1'b1, 1'b0, 1'b0, 1'b0);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("endrop_zbut", n_z, 0);

      // Enable rises with Z already held.
      clr();
      run(6, 1'b1, 1'b0, 1'b1, 1'b0);
      run(20, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("enrise_held_zbut", n_z, 0);
      chk("enrise_held_busy", n_b, 0);
      run(10, 1'b1, 1'b1, 1'b0, 1'b0);
      run(15, 1'b1, 1'b1, 1'b1, 1'b0);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("enrise_repress_zbut", n_z, 1);

      // Reset with the press count at 3.
      clr();
      run(5, 1'b1, 1'b1, 1'b1, 1'b0);
      run(2, 1'b0, 1'b1, 1'b0, 1'b0);
      run(20, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst_midcount_zbut", n_z, 0);

      // Random slowly-varying buttons with bounce, enable and reset events.
      rz = 1'b0; ro = 1'b0; ren = 1'b1; rrn = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(7) == 0)   rz  = ~rz;
         if ($urandom_range(7) == 0)   ro  = ~ro;
         if ($urandom_range(149) == 0) ren = ~ren;
         rrn = ($urandom_range(499) != 0);
         cyc(rrn, ren, rz, ro);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
